// File: rtl/sd_pkg.sv
// Shared constants for the SD command/response path.
// Holds the CRC7 geometry and polynomial plus the command frame length so
// that the CRC block and its users agree on a single definition.
package sd_pkg;

  // Width of the command/response checksum field.
  localparam int CRC7_LEN = 7;

  // Feedback taps for x^7 + x^3 + 1; the x^7 term is implicit.
  localparam logic [CRC7_LEN-1:0] CRC7_POLY = 7'h09;

  // Start bit, transmission bit, 6-bit index and 32-bit argument.
  localparam int CMD_LEN = 40;

  typedef logic [CRC7_LEN-1:0] crc7_t;

endpackage : sd_pkg

// File: rtl/crc7.sv
// Bit-serial CRC7 generator/checker for SD commands and responses.
// The frame is shifted in MSB-first while iunload is low.  Raising iunload
// then streams the 7-bit checksum out MSB-first on ocrc, zero-filling the
// register as it goes, so a fully unloaded register is back at zero.
// Optional feature: define CRC7_CHECK_EN to add ocrc_ok, which flags a
// zero remainder after message plus received CRC have been accumulated.
module crc7
  import sd_pkg::*;
#(
  parameter logic [CRC7_LEN-1:0] POLY = CRC7_POLY
) (
  input  logic iclk,
  input  logic irst,
  input  logic idata,
  input  logic iunload,
  output logic ocrc
`ifdef CRC7_CHECK_EN
  ,
  output logic ocrc_ok
`endif
);

  crc7_t r_q;
  crc7_t r_d;
  logic  fb;

  // Next-state: LFSR step while accumulating, plain zero-fill shift while unloading.
  always_comb begin
    r_d = {r_q[CRC7_LEN-2:0], 1'b0};
    fb  = idata ^ r_q[CRC7_LEN-1];
    if (!iunload && fb) begin
      r_d = {r_q[CRC7_LEN-2:0], 1'b0} ^ POLY;
    end
  end

  // Register update with reset taking priority over both modes.
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign ocrc = r_q[CRC7_LEN-1];

`ifdef CRC7_CHECK_EN
  assign ocrc_ok = (r_q == '0);
`endif

endmodule : crc7

// File: tb/tb_crc7.sv
// Directed self-checking bench for crc7.
// Inputs change on the falling edge and ocrc is sampled on the falling edge,
// i.e. just before the rising edge that consumes or shifts the register.
// Expected CRC values are the well-known SD checksums for the frames used.
module tb_crc7;
  import sd_pkg::*;

  logic iclk = 1'b0;
  logic irst;
  logic idata;
  logic iunload;
  logic ocrc;
`ifdef CRC7_CHECK_EN
  logic ocrc_ok;
`endif

  int errorCount = 0;
  int checkCount = 0;

  logic [CMD_LEN-1:0] cmd0;
  logic [CMD_LEN-1:0] cmd17;
  logic [CMD_LEN-1:0] resp17;
  logic [CMD_LEN-1:0] crcBits;
  logic [15:0]        captured;

  crc7 dut (
    .iclk    (iclk),
    .irst    (irst),
    .idata   (idata),
    .iunload (iunload),
    .ocrc    (ocrc)
`ifdef CRC7_CHECK_EN
    ,
    .ocrc_ok (ocrc_ok)
`endif
  );

  // Free-running 10 ns clock.
  always #5 iclk = ~iclk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One reset edge, with idata high and iunload low so any leakage would show.
  task automatic doReset();
    @(negedge iclk);
    irst    = 1'b1;
    idata   = 1'b1;
    iunload = 1'b0;
    @(posedge iclk);
    @(negedge iclk);
    irst    = 1'b0;
    idata   = 1'b0;
  endtask

  // Shifts the first nbits of a frame in, MSB-first, one bit per cycle.
  task automatic applyStimulus(input logic [CMD_LEN-1:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge iclk);
      irst    = 1'b0;
      iunload = 1'b0;
      idata   = frame[CMD_LEN-1-i];
      @(posedge iclk);
    end
  endtask

  // Holds iunload for n cycles, capturing ocrc just before each shift edge.
  task automatic unloadCapture(input int n, output logic [15:0] cap);
    cap = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge iclk);
      irst    = 1'b0;
      iunload = 1'b1;
      idata   = 1'b0;
      cap     = {cap[14:0], ocrc};
      @(posedge iclk);
    end
  endtask

  initial begin
    irst    = 1'b1;
    idata   = 1'b0;
    iunload = 1'b0;
    cmd0    = {2'b01, 6'd0, 32'h0000_0000};
    cmd17   = {2'b01, 6'd17, 32'h0000_0000};
    resp17  = {2'b00, 6'd17, 32'h0000_0900};

    $display("[TB] crc7 directed test start");

    // Reset state.
    doReset();
    checkOutput("reset_ocrc", {15'd0, ocrc}, 16'h0000);
`ifdef CRC7_CHECK_EN
    checkOutput("reset_ok", {15'd0, ocrc_ok}, 16'h0001);
`endif

    // CMD0 checksum, then the register must be empty.
    applyStimulus(cmd0, CMD_LEN);
    unloadCapture(7, captured);
    checkOutput("cmd0_crc", captured, 16'h004A);
    unloadCapture(7, captured);
    checkOutput("cmd0_after_unload", captured, 16'h0000);

    // CMD17 checksum.
    doReset();
    applyStimulus(cmd17, CMD_LEN);
    unloadCapture(7, captured);
    checkOutput("cmd17_crc", captured, 16'h002A);

    // RESP17 checksum.
    doReset();
    applyStimulus(resp17, CMD_LEN);
    unloadCapture(7, captured);
    checkOutput("resp17_crc", captured, 16'h0033);

    // Reset after 20 bits of CMD17 leaves no residue.
    doReset();
    applyStimulus(cmd17, 20);
    doReset();
    checkOutput("midframe_reset_ocrc", {15'd0, ocrc}, 16'h0000);
    applyStimulus(cmd17, CMD_LEN);
    unloadCapture(7, captured);
    checkOutput("cmd17_replay_crc", captured, 16'h002A);

    // Reset in the middle of an unload clears the rest of the checksum.
    doReset();
    applyStimulus(cmd17, CMD_LEN);
    unloadCapture(3, captured);
    checkOutput("partial_unload_bits", captured, 16'h0002);
    doReset();
    unloadCapture(7, captured);
    checkOutput("midunload_reset", captured, 16'h0000);

    // A single 1 from zero loads exactly the polynomial taps.
    doReset();
    applyStimulus({1'b1, 39'd0}, 1);
    unloadCapture(7, captured);
    checkOutput("single_one_poly", captured, 16'h0009);

    // Long unload after CMD0: checksum then zero fill.
    doReset();
    applyStimulus(cmd0, CMD_LEN);
    unloadCapture(10, captured);
    checkOutput("cmd0_long_unload", captured, 16'h0250);

`ifdef CRC7_CHECK_EN
    // Checker: CMD0 followed by its correct CRC gives a zero remainder.
    doReset();
    applyStimulus(cmd0, CMD_LEN);
    checkOutput("cmd0_not_ok_yet", {15'd0, ocrc_ok}, 16'h0000);
    crcBits = {7'b1001010, 33'd0};
    applyStimulus(crcBits, 7);
    @(negedge iclk);
    checkOutput("check_good_crc", {15'd0, ocrc_ok}, 16'h0001);

    // Checker: last CRC bit flipped leaves a nonzero remainder.
    doReset();
    applyStimulus(cmd0, CMD_LEN);
    crcBits = {7'b1001011, 33'd0};
    applyStimulus(crcBits, 7);
    @(negedge iclk);
    checkOutput("check_bad_crc", {15'd0, ocrc_ok}, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule : tb_crc7
